// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: turns MEM-stage load/store strobes into a valid/ack
// bus transaction, returns registered load data and generates the pipeline stall.
module dmem_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_e;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] tmo_q, tmo_d;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q, we_d;
  logic [31:0] baddr_q, baddr_d;
  logic [31:0] bwdata_q, bwdata_d;
  logic [3:0]  bwstrb_q, bwstrb_d;
  logic        err_q, err_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        access;

  assign access = mem_read | mem_write;

  // The DONE cycle is the single cycle in which MEM/WB is allowed to capture the result.
  assign stall = access & (state_q != DONE);

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    tmo_d       = tmo_q;
    rdata_d     = rdata_q;
    we_d        = we_q;
    baddr_d     = baddr_q;
    bwdata_d    = bwdata_q;
    bwstrb_d    = bwstrb_q;
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q + {31'd0, stall};

    unique case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (access) begin
          state_d  = REQ;
          we_d     = mem_write;
          baddr_d  = addr & 32'hFFFF_FFFC;
          bwdata_d = wdata;
          bwstrb_d = mem_write ? wmask : 4'b0000;
        end
      end
      REQ: begin
        if (bus_ack) begin
          state_d = DONE;
          if (!we_q) rdata_d = bus_rdata;
        end else if (tmo_q == TMO_LAST) begin
          // Abort: loads return zero so the pipeline never consumes stale data.
          state_d = DONE;
          err_d   = 1'b1;
          if (!we_q) rdata_d = 32'h0000_0000;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      rdata_q     <= '0;
      we_q        <= 1'b0;
      baddr_q     <= '0;
      bwdata_q    <= '0;
      bwstrb_q    <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      rdata_q     <= rdata_d;
      we_q        <= we_d;
      baddr_q     <= baddr_d;
      bwdata_q    <= bwdata_d;
      bwstrb_q    <= bwstrb_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus_req   = (state_q == REQ);
  assign bus_we    = we_q;
  assign bus_addr  = baddr_q;
  assign bus_wdata = bwdata_q;
  assign bus_wstrb = bwstrb_q;
  assign rdata     = rdata_q;
  assign bus_err   = err_q;
  assign stall_cnt = stall_cnt_q;

endmodule
